// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl -- initiator side of the multi-cycle divider handshake.
//
// Sits in EX. Accepts DIV/DIVU from the pipeline, latches the operands and
// sign mode for the divider, holds d_start until d_ready, and raises stall_req
// while the divide is pending. On completion it writes {HI=remainder,
// LO=quotient} through a one-cycle hilo_we strobe. A pipeline flush kills the
// in-flight divide: the divider is told to abandon and the controller drains
// the outstanding result without writing it. A watchdog returns to IDLE with a
// div_err pulse if d_ready never arrives.
//
// Optional feature macro: DIV_ZBYPASS_EN
//   When defined, a zero divisor completes in IDLE without a divider handshake
//   (HI=LO=0, hilo_we next cycle, no stall).
//
// Parameters
//   TIMEOUT     cycles allowed in BUSY/DRAIN before declaring a timeout
//
// Ports
//   clk          clock, posedge
//   rst          synchronous active-low reset
//   div_req      EX holds a DIV/DIVU (held with operands while stall_req=1)
//   div_signed   1=DIV, 0=DIVU
//   div_opr1     dividend
//   div_opr2     divisor
//   flush        pipeline flush, kills the in-flight divide
//   stall_req    combinational EX hold
//   hilo_we      one-cycle HI/LO write strobe
//   hi_o / lo_o  remainder / quotient, valid with hilo_we
//   div_err      one-cycle timeout pulse
//   d_start      divider start level, held until d_ready seen
//   d_abandon    divider abandon pulse
//   d_signed     latched sign mode
//   d_opr1/2     latched operands, stable while d_start=1
//   d_ready      divider result valid
//   d_res        {remainder, quotient}

module div_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] div_opr1,
  input  logic [31:0] div_opr2,
  input  logic        flush,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_err,
  output logic        d_start,
  output logic        d_abandon,
  output logic        d_signed,
  output logic [31:0] d_opr1,
  output logic [31:0] d_opr2,
  input  logic        d_ready,
  input  logic [63:0] d_res
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_start;
  logic          r_abandon;
  logic          r_signed;
  logic [31:0]   r_opr1;
  logic [31:0]   r_opr2;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_we;
  logic          r_err;
  logic          w_zbyp;
  logic          w_accept;
  logic          w_timeout;

`ifdef DIV_ZBYPASS_EN
  assign w_zbyp = (div_opr2 == '0);
`else
  assign w_zbyp = 1'b0;
`endif

  assign w_accept  = div_req & ~flush & ~w_zbyp;
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY: begin
        // d_ready beats flush: a finished result is simply not written.
        if (d_ready)        w_next = S_IDLE;
        else if (flush)     w_next = S_DRAIN;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DRAIN: if (d_ready || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    stall_req = 1'b0;
    unique case (r_state)
      S_IDLE:  stall_req = w_accept;
      S_BUSY:  stall_req = ~d_ready & ~flush;
      S_DRAIN: stall_req = div_req;
      default: stall_req = 1'b0;
    endcase
  end

  // Handshake and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_abandon <= 1'b0;
      r_signed  <= 1'b0;
      r_opr1    <= '0;
      r_opr2    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_abandon <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (div_req && !flush) begin
            if (w_zbyp) begin
              r_hi <= '0;
              r_lo <= '0;
              r_we <= 1'b1;
            end else begin
              r_signed <= div_signed;
              r_opr1   <= div_opr1;
              r_opr2   <= div_opr2;
              r_start  <= 1'b1;
              r_cnt    <= '0;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (d_ready) begin
            r_start <= 1'b0;
            if (!flush) begin
              r_hi <= d_res[63:32];
              r_lo <= d_res[31:0];
              r_we <= 1'b1;
            end
          end else if (flush) begin
            // d_start stays high so the divider can finish and be drained.
            r_abandon <= 1'b1;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_start <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (d_ready) begin
            r_start <= 1'b0;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_start <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hilo_we   = r_we;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;
  assign div_err   = r_err;
  assign d_start   = r_start;
  assign d_abandon = r_abandon;
  assign d_signed  = r_signed;
  assign d_opr1    = r_opr1;
  assign d_opr2    = r_opr2;

endmodule
